vga_sync_gen: RTL and testbench

//  Pixel-timing generator for the Pxs video path: horizontal/vertical counters, sync pulses,

---
 rtl/vga_sync_gen_pkg.sv | 17 +
 rtl/vga_axis_cnt.sv | 37 +++
 rtl/vga_sync_gen.sv | 61 ++++++
 tb/tb_vga_sync_gen.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// vga_sync_gen_pkg: shared Pxs timing defaults (640x480 @ 60 Hz, 25 MHz pixel clock) and helpers
package vga_sync_gen_pkg;
   localparam int unsigned CNT_W       = 10;
   localparam int unsigned H_VISIBLE_D = 640;
   localparam int unsigned H_FRONT_D   = 16;
   localparam int unsigned H_SYNC_D    = 96;
   localparam int unsigned H_BACK_D    = 48;
   localparam int unsigned V_VISIBLE_D = 480;
   localparam int unsigned V_FRONT_D   = 10;
   localparam int unsigned V_SYNC_D    = 2;
   localparam int unsigned V_BACK_D    = 33;
   localparam bit          SYNC_POL_D  = 1'b0;

   function automatic int unsigned axis_total(int unsigned vis, int unsigned front, int unsigned sync, int unsigned back);
      return vis + front + sync + back;
   endfunction
endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: modulo counter for one video axis with a registered sync-window flag
module vga_axis_cnt
   import vga_sync_gen_pkg::*;
#(
   parameter int unsigned VIS   = H_VISIBLE_D,
   parameter int unsigned FRONT = H_FRONT_D,
   parameter int unsigned SYNC  = H_SYNC_D,
   parameter int unsigned BACK  = H_BACK_D
) (
   input  logic             px_clk,
   input  logic             reset,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap,
   output logic             sync_act
);
   localparam int unsigned TOTAL = axis_total(VIS, FRONT, SYNC, BACK);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W:0]   S_LO = (CNT_W + 1)'(VIS + FRONT);
   localparam logic [CNT_W:0]   S_HI = (CNT_W + 1)'(VIS + FRONT + SYNC);

   logic [CNT_W-1:0] nxt;

   assign wrap = en && (cnt == LAST);
   assign nxt  = wrap ? '0 : en ? cnt + 1'b1 : cnt;

   // Count with wrap by compare; sync flag is decoded from the next count so it tracks cnt
   always_ff @(posedge px_clk) begin
      if (reset) begin
         cnt      <= '0;
         sync_act <= 1'b0;
      end else begin
         cnt      <= nxt;
         sync_act <= ({1'b0, nxt} >= S_LO) && ({1'b0, nxt} < S_HI);
      end
   end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: Pxs pixel-timing generator; define PXS_FRAMECNT_EN to add the frame_cnt output
module vga_sync_gen
   import vga_sync_gen_pkg::*;
#(
   parameter int unsigned H_VISIBLE = H_VISIBLE_D,
   parameter int unsigned H_FRONT   = H_FRONT_D,
   parameter int unsigned H_SYNC    = H_SYNC_D,
   parameter int unsigned H_BACK    = H_BACK_D,
   parameter int unsigned V_VISIBLE = V_VISIBLE_D,
   parameter int unsigned V_FRONT   = V_FRONT_D,
   parameter int unsigned V_SYNC    = V_SYNC_D,
   parameter int unsigned V_BACK    = V_BACK_D,
   parameter bit          SYNC_POL  = SYNC_POL_D
) (
   input  logic             px_clk,
   input  logic             reset,
   output logic             hsync,
   output logic             vsync,
   output logic             activevideo,
   output logic [CNT_W-1:0] x_px,
   output logic [CNT_W-1:0] y_px,
   output logic             endframe
`ifdef PXS_FRAMECNT_EN
  ,output logic [7:0]       frame_cnt
`endif
);
   logic [CNT_W-1:0] hc, vc, h_nxt, v_nxt;
   logic             h_wrap, v_wrap, h_act, v_act, ef_nxt;

   vga_axis_cnt #(.VIS(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)) u_h (
      .px_clk(px_clk), .reset(reset), .en(1'b1), .cnt(hc), .wrap(h_wrap), .sync_act(h_act)
   );

   vga_axis_cnt #(.VIS(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)) u_v (
      .px_clk(px_clk), .reset(reset), .en(h_wrap), .cnt(vc), .wrap(v_wrap), .sync_act(v_act)
   );

   assign x_px   = hc;
   assign y_px   = vc;
   assign hsync  = h_act ? SYNC_POL : ~SYNC_POL;
   assign vsync  = v_act ? SYNC_POL : ~SYNC_POL;
   assign h_nxt  = h_wrap ? '0 : hc + 1'b1;
   assign v_nxt  = v_wrap ? '0 : h_wrap ? vc + 1'b1 : vc;
   assign ef_nxt = (h_nxt == '0) && (v_nxt == CNT_W'(V_VISIBLE));

   // Decode the position the counters move to, so flags line up with x_px/y_px on the same edge
   always_ff @(posedge px_clk) begin
      if (reset) begin
         activevideo <= 1'b1;
         endframe    <= 1'b0;
      end else begin
         activevideo <= (h_nxt < CNT_W'(H_VISIBLE)) && (v_nxt < CNT_W'(V_VISIBLE));
         endframe    <= ef_nxt;
      end
   end

`ifdef PXS_FRAMECNT_EN
   // Frames since reset, advancing on the same edge that raises endframe
   always_ff @(posedge px_clk) frame_cnt <= reset ? '0 : frame_cnt + {7'd0, ef_nxt};
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: random-reset directed bench for vga_sync_gen against an arithmetic timing model
module tb_vga_sync_gen;
   localparam int HV = 8, HF = 2, HS = 3, HB = 3;
   localparam int VV = 6, VF = 1, VS = 2, VB = 2;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FT = HT * VT;

   logic       px_clk = 1'b0;
   logic       reset  = 1'b1;
   logic       hsync, vsync, activevideo, endframe;
   logic [9:0] x_px, y_px;
`ifdef PXS_FRAMECNT_EN
   logic [7:0] frame_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int t      = 0;
   int cyc    = 0;

   always #20 px_clk = ~px_clk;

   vga_sync_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0)
   ) dut (
      .px_clk(px_clk), .reset(reset), .hsync(hsync), .vsync(vsync),
      .activevideo(activevideo), .x_px(x_px), .y_px(y_px), .endframe(endframe)
`ifdef PXS_FRAMECNT_EN
     ,.frame_cnt(frame_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, got, exp, t);
      end
   endtask

   // Model: position is just elapsed cycles since reset, folded by line and frame length
   task automatic check_all();
      int hc, vc, ef;
      hc = t % HT;
      vc = (t / HT) % VT;
      chk("x_px", x_px, hc);
      chk("y_px", y_px, vc);
      chk("activevideo", activevideo, (hc < HV && vc < VV) ? 1 : 0);
      chk("hsync", hsync, (hc >= HV + HF && hc < HV + HF + HS) ? 0 : 1);
      chk("vsync", vsync, (vc >= VV + VF && vc < VV + VF + VS) ? 0 : 1);
      chk("endframe", endframe, (hc == 0 && vc == VV) ? 1 : 0);
`ifdef PXS_FRAMECNT_EN
      ef = (t >= VV * HT) ? (t - VV * HT) / FT + 1 : 0;
      chk("frame_cnt", frame_cnt, ef % 256);
`else
      ef = 0;
`endif
   endtask

   task automatic tick();
      @(posedge px_clk);
      #1;
      cyc++;
      if (reset) t = 0;
      else t++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check_all();
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         check_all();
      end
      reset = 1'b0;
   endtask

   initial begin
      int last_ef, hs_lo, vs_lo, av_hi, n;
      // Reset held for 3 cycles, then release
      do_reset(3);
      chk("rst_x", x_px, 0);
      chk("rst_hsync", hsync, 1);
      chk("rst_av", activevideo, 1);
      // Three frames: per-cycle model plus endframe spacing and per-frame window totals
      last_ef = -1;
      hs_lo = 0; vs_lo = 0; av_hi = 0;
      for (int i = 0; i < 3 * FT; i++) begin
         tick();
         check_all();
         if (endframe) begin
            if (last_ef >= 0) chk("ef_period", cyc - last_ef, FT);
            last_ef = cyc;
         end
         if (i < FT) begin
            hs_lo += (hsync == 1'b0) ? 1 : 0;
            vs_lo += (vsync == 1'b0) ? 1 : 0;
            av_hi += activevideo ? 1 : 0;
         end
      end
      chk("hs_low_per_frame", hs_lo, HS * VT);
      chk("vs_low_per_frame", vs_lo, VS * HT);
      chk("av_per_frame", av_hi, HV * VV);
      // Reset mid-sync at a point inside both hsync and vsync windows
      do_reset(1);
      run((VV + VF) * HT + HV + HF + 1);
      chk("pre_x", x_px, HV + HF + 1);
      chk("pre_y", y_px, VV + VF);
      do_reset(1);
      chk("mid_rst_hsync", hsync, 1);
      chk("mid_rst_vsync", vsync, 1);
      n = 0;
      while (n < 2 * FT) begin
         tick();
         n++;
         check_all();
         if (endframe) break;
      end
      chk("ef_after_rst", n, VV * HT);
      // Random reset points and hold lengths
      for (int k = 0; k < 6; k++) begin
         run($urandom_range(2 * FT, 0));
         do_reset($urandom_range(3, 1));
      end
      run(FT + 5);
`ifdef PXS_FRAMECNT_EN
      // Frame counter wraps past 255 and clears on reset
      do_reset(1);
      run(256 * FT + VV * HT);
      chk("fc_after_wrap", frame_cnt, 1);
      do_reset(1);
      chk("fc_rst", frame_cnt, 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
